// File: rtl/hud_display_arbiter.sv
// Round-robin arbiter sharing the HUD digit-scan stage between score, coins, timer
// and lives; event requests take a flashing overlay for HOLD_MS display clocks.
module hud_display_arbiter #(
  parameter int unsigned HOLD_MS     = 2000,
  parameter int unsigned FLASH_HALF  = 250,
  parameter int unsigned DEFAULT_SRC = 0
) (
  input  logic        clk_1000hz,
  input  logic        rst,
  input  logic [31:0] score,
  input  logic [31:0] coins,
  input  logic [31:0] timer,
  input  logic [31:0] lives,
  input  logic [3:0]  req,
  output logic [3:0]  ack,
  output logic [31:0] value,
  output logic [1:0]  src,
  output logic        overlay,
  output logic [7:0]  blank
);

  localparam int unsigned     HW         = $clog2(HOLD_MS);
  localparam int unsigned     FW         = (FLASH_HALF > 2) ? $clog2(FLASH_HALF) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD  = HW'(HOLD_MS - 1);
  localparam logic [FW-1:0]   FLASH_LOAD = FW'((FLASH_HALF == 0) ? 0 : FLASH_HALF - 1);
  localparam logic [1:0]      DEF        = 2'(DEFAULT_SRC);
  localparam logic [31:0]     SAT_MAX    = 32'd99_999_999;

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t          r_state;
  logic [3:0]      r_pend;
  logic [1:0]      r_last;
  logic [1:0]      r_cur;
  logic [HW-1:0]   r_hold;
  logic [FW-1:0]   r_fcnt;
  logic            r_phase;

  state_t          w_state_n;
  logic [3:0]      w_pend_n;
  logic [1:0]      w_last_n;
  logic [1:0]      w_cur_n;
  logic [3:0]      w_ack_n;
  logic [HW-1:0]   w_hold_n;
  logic [FW-1:0]   w_fcnt_n;
  logic            w_phase_n;
  logic            w_grant;
  logic [2:0]      w_pick;
  logic [3:0]      w_cur_hot;
  logic [3:0]      w_win_hot;
  logic [1:0]      w_src_n;
  logic [31:0]     w_sel;
  logic [31:0]     w_val_n;
  logic [7:0]      w_blank_n;

  // {valid, index} of the first set bit searching last+1, last+2, ... mod 4
  function automatic logic [2:0] rr_pick(input logic [3:0] p, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = '0;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (p[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  function automatic logic [7:0] lz_mask(input logic [31:0] v);
    logic [31:0] pw;
    lz_mask = '0;
    pw      = 32'd1;
    for (int unsigned i = 1; i < 8; i++) begin
      pw         = pw * 32'd10;
      lz_mask[i] = (v < pw);
    end
  endfunction

  always_comb begin
    w_pick    = rr_pick(r_pend | req, r_last);
    w_cur_hot = 4'b0001 << r_cur;
    w_win_hot = 4'b0001 << w_pick[1:0];
  end

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend | req;
    w_last_n  = r_last;
    w_cur_n   = r_cur;
    w_ack_n   = '0;
    w_hold_n  = r_hold;
    w_fcnt_n  = r_fcnt;
    w_phase_n = r_phase;
    w_grant   = 1'b0;
    case (r_state)
      S_IDLE: w_grant = w_pick[2];
      default: begin
        if ((req & w_cur_hot) != '0) begin
          // retrigger of the held source: restart timing, never pended
          w_pend_n = r_pend | (req & ~w_cur_hot);
          w_ack_n  = w_cur_hot;
          w_hold_n = HOLD_LOAD;
          w_fcnt_n = FLASH_LOAD;
        end else if (r_hold == '0) begin
          if (w_pick[2]) begin
            w_grant = 1'b1;
          end else begin
            w_state_n = S_IDLE;
            w_phase_n = 1'b0;
            w_fcnt_n  = '0;
          end
        end else begin
          w_hold_n = r_hold - 1'b1;
          if (FLASH_HALF != 0) begin
            if (r_fcnt == '0) begin
              w_phase_n = ~r_phase;
              w_fcnt_n  = FLASH_LOAD;
            end else begin
              w_fcnt_n = r_fcnt - 1'b1;
            end
          end
        end
      end
    endcase
    if (w_grant) begin
      w_state_n = S_HOLD;
      w_cur_n   = w_pick[1:0];
      w_last_n  = w_pick[1:0];
      w_ack_n   = w_win_hot;
      w_pend_n  = (r_pend | req) & ~w_win_hot;
      w_hold_n  = HOLD_LOAD;
      w_fcnt_n  = FLASH_LOAD;
      w_phase_n = 1'b0;
    end
  end

  // value and blank follow the next-state source so they land with src
  always_comb begin
    w_src_n = (w_state_n == S_HOLD) ? w_cur_n : DEF;
    case (w_src_n)
      2'd0:    w_sel = score;
      2'd1:    w_sel = coins;
      2'd2:    w_sel = timer;
      default: w_sel = lives;
    endcase
    w_val_n   = (w_sel > SAT_MAX) ? SAT_MAX : w_sel;
    w_blank_n = ((w_state_n == S_HOLD) && w_phase_n) ? 8'hFF : lz_mask(w_val_n);
  end

  always_ff @(posedge clk_1000hz or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_last  <= 2'd3;
      r_cur   <= DEF;
      r_hold  <= '0;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
      ack     <= '0;
      value   <= '0;
      src     <= DEF;
      overlay <= 1'b0;
      blank   <= 8'hFE;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_last  <= w_last_n;
      r_cur   <= w_cur_n;
      r_hold  <= w_hold_n;
      r_fcnt  <= w_fcnt_n;
      r_phase <= w_phase_n;
      ack     <= w_ack_n;
      value   <= w_val_n;
      src     <= w_src_n;
      overlay <= (w_state_n == S_HOLD);
      blank   <= w_blank_n;
    end
  end

endmodule

// File: tb/tb_hud_display_arbiter.sv
// Bench for hud_display_arbiter: directed scenarios plus random requests, checked
// every cycle against a timestamp-based reference model.
module tb_hud_display_arbiter;

  localparam int unsigned HOLD = 2000;
  localparam int unsigned FH   = 250;
  localparam int unsigned DEF  = 0;

  logic        clk;
  logic        rst;
  logic [31:0] score, coins, timer, lives;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [31:0] value;
  logic [1:0]  src;
  logic        overlay;
  logic [7:0]  blank;

  hud_display_arbiter #(
    .HOLD_MS    (HOLD),
    .FLASH_HALF (FH),
    .DEFAULT_SRC(DEF)
  ) dut (
    .clk_1000hz(clk),
    .rst       (rst),
    .score     (score),
    .coins     (coins),
    .timer     (timer),
    .lives     (lives),
    .req       (req),
    .ack       (ack),
    .value     (value),
    .src       (src),
    .overlay   (overlay),
    .blank     (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: overlay tracked as absolute edge times, flash phase derived by division
  longint   t_edge = 0;
  bit       m_active;
  int       m_cur;
  int       m_last;
  bit [3:0] m_pend;
  longint   m_end;
  longint   m_rel;
  bit       m_base;
  logic [3:0]  e_ack;
  logic [1:0]  e_src;
  logic        e_ovl;
  logic [31:0] e_val;
  logic [7:0]  e_blank;

  function automatic int rr(input bit [3:0] p, input int last);
    for (int k = 1; k <= 4; k++)
      if (p[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic bit phase_at(input longint tt);
    if (!m_active || FH == 0) return 1'b0;
    return m_base ^ bit'(((tt - m_rel) / FH) % 2);
  endfunction

  function automatic logic [7:0] lz(input longint v);
    logic [7:0] m;
    longint     p;
    m = '0;
    p = 1;
    for (int i = 1; i < 8; i++) begin
      p    = p * 10;
      m[i] = (v < p);
    end
    return m;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_last   = 3;
    m_pend   = '0;
    e_ack    = '0;
    e_src    = 2'(DEF);
    e_ovl    = 1'b0;
    e_val    = '0;
    e_blank  = 8'hFE;
  endtask

  task automatic model_grant(input int w, input bit [3:0] p);
    m_active = 1'b1;
    m_cur    = w;
    m_last   = w;
    m_end    = t_edge + HOLD;
    m_rel    = t_edge;
    m_base   = 1'b0;
    m_pend   = p & ~(4'b1 << w);
    e_ack    = 4'b1 << w;
  endtask

  task automatic model_edge();
    bit [3:0] p;
    int       w;
    longint   v;
    t_edge++;
    e_ack = '0;
    p = m_pend | req;
    if (!m_active) begin
      w = rr(p, m_last);
      if (w >= 0) model_grant(w, p);
      else m_pend = p;
    end else if (req[m_cur]) begin
      m_base = phase_at(t_edge - 1);
      m_rel  = t_edge;
      m_end  = t_edge + HOLD;
      m_pend = m_pend | (req & ~(4'b1 << m_cur));
      e_ack  = 4'b1 << m_cur;
    end else if (t_edge == m_end) begin
      w = rr(p, m_last);
      if (w >= 0) model_grant(w, p);
      else begin
        m_active = 1'b0;
        m_pend   = p;
      end
    end else begin
      m_pend = p;
    end
    e_src = m_active ? 2'(m_cur) : 2'(DEF);
    e_ovl = m_active;
    case (e_src)
      2'd0:    v = score;
      2'd1:    v = coins;
      2'd2:    v = timer;
      default: v = lives;
    endcase
    if (v >= 100_000_000) v = 99_999_999;
    e_val   = 32'(v);
    e_blank = (m_active && phase_at(t_edge)) ? 8'hFF : lz(v);
  endtask

  task automatic check_outputs();
    check("ack", 32'(ack), 32'(e_ack));
    check("src", 32'(src), 32'(e_src));
    check("overlay", 32'(overlay), 32'(e_ovl));
    check("value", value, e_val);
    check("blank", 32'(blank), 32'(e_blank));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 999);
      2:       return $urandom_range(0, 120_000_000);
      default: return $urandom_range(9_999_990, 10_000_010);
    endcase
  endfunction

  int cnt;

  initial begin
    rst = 1'b0; req = '0;
    score = 32'd1234; coins = '0; timer = '0; lives = '0;
    model_reset();

    // reset state while rst is held, then first edge after release
    #1 rst = 1'b1;
    #1 check_outputs();
    check("rst_value", value, 32'd0);
    check("rst_blank", 32'(blank), 32'hFE);
    run(2);
    rst = 1'b0;
    step();
    check("first_value", value, 32'd1234);
    check("first_blank", 32'(blank), 32'hF0);
    check("first_src", 32'(src), 32'd0);

    // single coins request with flashing and exact return time
    coins = 32'd7;
    req = 4'b0010;
    step();
    req = '0;
    check("coin_ack", 32'(ack), 32'b0010);
    check("coin_src", 32'(src), 32'd1);
    check("coin_value", value, 32'd7);
    check("coin_blank", 32'(blank), 32'hFE);
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (k == 249) check("flash_249", 32'(blank), 32'hFE);
      if (k == 250) check("flash_250", 32'(blank), 32'hFF);
      if (k == 499) check("flash_499", 32'(blank), 32'hFF);
      if (k == 500) check("flash_500", 32'(blank), 32'hFE);
      if (k == 1999) check("hold_1999", 32'(overlay), 32'd1);
      if (k == 2000) begin
        check("ret_src", 32'(src), 32'd0);
        check("ret_ovl", 32'(overlay), 32'd0);
      end
    end

    // all four requested at once: back-to-back in order 0..3
    async_reset();
    req = 4'b1111;
    step();
    req = '0;
    check("rr_ack0", 32'(ack), 32'b0001);
    for (int k = 1; k <= 8000; k++) begin
      step();
      if (k % 2000 == 0 && k < 8000) begin
        check("rr_ack", 32'(ack), 32'(4'b1 << (k / 2000)));
        check("rr_ovl", 32'(overlay), 32'd1);
      end
      if (k == 8000) check("rr_idle", 32'(overlay), 32'd0);
    end

    // retrigger of held timer source extends the hold
    async_reset();
    timer = 32'd4321;
    req = 4'b0100;
    step();
    req = '0;
    check("tmr_ack", 32'(ack), 32'b0100);
    cnt = 0;
    for (int k = 1; k <= 3600; k++) begin
      req = (k == 1501) ? 4'b0100 : 4'b0000;
      step();
      if (k == 1501) check("retrig_ack", 32'(ack), 32'b0100);
      if (k > 1501 && ack != '0) cnt++;
      if (k == 3500) check("ext_ovl", 32'(overlay), 32'd1);
      if (k == 3501) begin
        check("ext_end_ovl", 32'(overlay), 32'd0);
        check("ext_end_src", 32'(src), 32'd0);
      end
    end
    req = '0;
    check("retrig_not_pended", cnt, 0);

    // saturation and leading-zero blanking on lives
    async_reset();
    lives = 32'd150_000_000;
    req = 4'b1000;
    step();
    req = '0;
    check("sat_value", value, 32'd99_999_999);
    check("sat_blank", 32'(blank), 32'h00);
    lives = 32'd0;
    step();
    check("zero_blank", 32'(blank), 32'hFE);
    lives = 32'd10_000_000;
    step();
    check("10m_blank", 32'(blank), 32'h00);
    lives = 32'd9_999_999;
    step();
    check("9m_blank", 32'(blank), 32'h80);
    check("9m_value", value, 32'd9_999_999);
    run(2000);

    // reset mid-hold drops the pending lives request
    async_reset();
    req = 4'b0010;
    step();
    req = '0;
    for (int k = 1; k < 700; k++) begin
      req = (k == 100) ? 4'b1000 : 4'b0000;
      step();
    end
    req = '0;
    rst = 1'b1;
    #2;
    model_reset();
    check_outputs();
    check("mid_rst_src", 32'(src), 32'(DEF));
    check("mid_rst_ovl", 32'(overlay), 32'd0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (ack != '0) cnt++;
    end
    check("pend_lost", cnt, 0);

    // random traffic
    for (int k = 0; k < 20000; k++) begin
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0:       score = rand_val();
          1:       coins = rand_val();
          2:       timer = rand_val();
          default: lives = rand_val();
        endcase
      end
      for (int b = 0; b < 4; b++) req[b] = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 4999) == 0) async_reset();
      else step();
    end
    req = '0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
